// File: rtl/program_loader.sv
// Purpose : boot loader; unpacks a byte stream into imem words and dmem bytes, then releases the core.
// Latency : write strobe 1 cycle after the completing byte; start_o 2 cycles after the final byte.
// Backpr. : byte_ready_o is registered from state only; it drops for good in FINISH/RUN/ERR.
//
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   byte_i/_valid_i/_ready_o stream input handshake
//   imem_we_o/addr_o/data_o  instruction memory write port (word index, 32-bit word)
//   dmem_we_o/addr_o/data_o  data memory write port (byte address, byte)
//   start_o, err_o           sticky completion / format-error flags
//   words_loaded_o           number of instruction words written so far
module program_loader #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [7:0]  imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        dmem_we_o,
    output logic [4:0]  dmem_addr_o,
    output logic [7:0]  dmem_data_o,
    output logic        start_o,
    output logic        err_o,
    output logic [8:0]  words_loaded_o
);

    localparam logic [2:0] S_HDR_LO = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_IWORD  = 3'd2;
    localparam logic [2:0] S_DCNT   = 3'd3;
    localparam logic [2:0] S_DBYTE  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;
    localparam logic [2:0] S_RUN    = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [15:0] LP_IMEM_MAX = 16'(IMEM_WORDS);
    localparam logic [7:0]  LP_DMEM_MAX = 8'(DMEM_BYTES);

    logic [2:0]  r_state;
    logic        r_ready;
    logic [15:0] r_n;
    logic [1:0]  r_bcnt;
    logic [23:0] r_part;      // bytes 0..2 of the word in progress, byte 0 in [7:0] once full
    logic [7:0]  r_widx;
    logic [8:0]  r_words;
    logic [7:0]  r_m;
    logic [7:0]  r_didx;
    logic        r_imem_we;
    logic [7:0]  r_imem_addr;
    logic [31:0] r_imem_data;
    logic        r_dmem_we;
    logic [4:0]  r_dmem_addr;
    logic [7:0]  r_dmem_data;
    logic        r_start;
    logic        r_err;

    logic        w_acc;
    logic [15:0] w_n_full;
    logic        w_last_word;
    logic        w_last_dbyte;
    logic [2:0]  w_state_nxt;
    logic        w_ready_nxt;

    assign w_acc        = byte_valid_i & r_ready;
    assign w_n_full     = {byte_i, r_n[7:0]};
    assign w_last_word  = ({8'd0, r_widx} == (r_n - 16'd1));
    assign w_last_dbyte = (r_didx == (r_m - 8'd1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR_LO: if (w_acc) w_state_nxt = S_HDR_HI;
            S_HDR_HI: begin
                if (w_acc) begin
                    if (w_n_full == 16'd0 || w_n_full > LP_IMEM_MAX) w_state_nxt = S_ERR;
                    else                                              w_state_nxt = S_IWORD;
                end
            end
            S_IWORD:  if (w_acc && r_bcnt == 2'd3 && w_last_word) w_state_nxt = S_DCNT;
            S_DCNT: begin
                if (w_acc) begin
                    if (byte_i > LP_DMEM_MAX) w_state_nxt = S_ERR;
                    else if (byte_i == 8'd0)  w_state_nxt = S_FINISH;
                    else                      w_state_nxt = S_DBYTE;
                end
            end
            S_DBYTE:  if (w_acc && w_last_dbyte) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_RUN;
            default:  w_state_nxt = r_state;   // RUN and ERR are terminal until reset
        endcase
    end

    // Ready is registered from the next state so it never sees byte_valid_i
    // combinationally and is low while reset is held.
    always_comb begin
        w_ready_nxt = w_state_nxt inside {S_HDR_LO, S_HDR_HI, S_IWORD, S_DCNT, S_DBYTE};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_HDR_LO;
            r_ready     <= 1'b0;
            r_n         <= 16'd0;
            r_bcnt      <= 2'd0;
            r_part      <= 24'd0;
            r_widx      <= 8'd0;
            r_words     <= 9'd0;
            r_m         <= 8'd0;
            r_didx      <= 8'd0;
            r_imem_we   <= 1'b0;
            r_imem_addr <= 8'd0;
            r_imem_data <= 32'd0;
            r_dmem_we   <= 1'b0;
            r_dmem_addr <= 5'd0;
            r_dmem_data <= 8'd0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= w_ready_nxt;
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;
            if (w_state_nxt == S_ERR) r_err   <= 1'b1;
            if (w_state_nxt == S_RUN) r_start <= 1'b1;
            if (w_acc) begin
                case (r_state)
                    S_HDR_LO: r_n[7:0]  <= byte_i;
                    S_HDR_HI: r_n[15:8] <= byte_i;
                    S_IWORD: begin
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_imem_we   <= 1'b1;
                            r_imem_addr <= r_widx;
                            r_imem_data <= {byte_i, r_part};
                            r_widx      <= r_widx + 8'd1;
                            if ({7'd0, r_words} < r_n) r_words <= r_words + 9'd1;
                        end else begin
                            // shift in from the top so the first byte ends up lowest
                            r_part <= {byte_i, r_part[23:8]};
                        end
                    end
                    S_DCNT: begin
                        r_m    <= byte_i;
                        r_didx <= 8'd0;
                    end
                    S_DBYTE: begin
                        r_dmem_we   <= 1'b1;
                        r_dmem_addr <= r_didx[4:0];
                        r_dmem_data <= byte_i;
                        r_didx      <= r_didx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready_o   = r_ready;
    assign imem_we_o      = r_imem_we;
    assign imem_addr_o    = r_imem_addr;
    assign imem_data_o    = r_imem_data;
    assign dmem_we_o      = r_dmem_we;
    assign dmem_addr_o    = r_dmem_addr;
    assign dmem_data_o    = r_dmem_data;
    assign start_o        = r_start;
    assign err_o          = r_err;
    assign words_loaded_o = r_words;

endmodule
